// File: rtl/cen_pkg.sv
// Shared types and constants for the centering-datapath sequencer.
package cen_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        SUM       = 3'd2,
        SUM_DRAIN = 3'd3,
        DIV       = 3'd4,
        SUB       = 3'd5,
        SUB_DRAIN = 3'd6,
        DONE      = 3'd7
    } cen_state_t;

    // Sample-buffer read latency: data appears the cycle after rd_en.
    localparam int CEN_RD_LAT = 1;

endpackage

// File: rtl/cen_addr_cnt.sv
// Loadable sample-buffer address counter with enable, sync clear and terminal-count flag.
module cen_addr_cnt #(
    parameter int N_SAMPLES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              en,
    output logic [ADDR_W-1:0] count,
    output logic              tc
);

    assign tc = (count == ADDR_W'(N_SAMPLES - 1));

    // Saturates at terminal count so no wrap is ever visible on the address bus.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cen_sequencer.sv
// Two-pass centering sequencer: accumulate, wait for the mean divider, then stream
// mean-subtracted samples downstream under valid/ready, all via clock-enable strobes.
module cen_sequencer
    import cen_pkg::*;
#(
    parameter int N_SAMPLES = 1024,
    parameter int ADDR_W    = 10,
    parameter int DIV_LAT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              clr_sum,
    output logic              en_sum,
    output logic              div_start,
    output logic              en_div,
    output logic              en_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr
);

    localparam int DIV_W = $clog2(DIV_LAT) + 1;

    cen_state_t             state;
    cen_state_t             next_state;
    logic [DIV_W-1:0]       div_cnt;
    logic                   cnt_clr;
    logic                   cnt_tc;
    logic                   issue;
    logic                   last_div;
    logic [CEN_RD_LAT-1:0]  sum_pipe;

    // A new SUB read is allowed only when the output slot is empty or draining.
    assign issue    = !out_valid || out_ready;
    assign last_div = (div_cnt == DIV_W'(DIV_LAT - 1));
    assign cnt_clr  = !(state == SUM || state == SUB);

    cen_addr_cnt #(
        .N_SAMPLES (N_SAMPLES),
        .ADDR_W    (ADDR_W)
    ) u_addr_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (rd_en),
        .count    (rd_addr),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        next_state = state;
        unique case (state)
            IDLE:      if (go) next_state = CLEAR;
            CLEAR:     next_state = SUM;
            SUM:       if (cnt_tc) next_state = SUM_DRAIN;
            SUM_DRAIN: next_state = DIV;
            DIV:       if (last_div) next_state = SUB;
            SUB:       if (issue && cnt_tc) next_state = SUB_DRAIN;
            SUB_DRAIN: if (out_valid && out_ready) next_state = DONE;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = 1'b0;
        rd_en     = 1'b0;
        clr_sum   = 1'b0;
        div_start = 1'b0;
        en_div    = 1'b0;
        unique case (state)
            CLEAR: clr_sum = 1'b1;
            SUM:   rd_en   = 1'b1;
            DIV: begin
                div_start = (div_cnt == '0);
                en_div    = last_div;
            end
            SUB:   rd_en = issue;
            DONE:  done  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state != DIV) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Output register pipeline: strobes line up with the data returned by the buffer.
    assign en_sum = sum_pipe[CEN_RD_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_pipe  <= '0;
            out_valid <= 1'b0;
            en_sub    <= 1'b0;
            out_addr  <= '0;
        end else begin
            sum_pipe <= CEN_RD_LAT'({sum_pipe, (rd_en && state == SUM)});
            if (state == SUB && issue) begin
                out_valid <= 1'b1;
                en_sub    <= 1'b1;
                out_addr  <= rd_addr;
            end else if (out_ready || !(state == SUB || state == SUB_DRAIN)) begin
                out_valid <= 1'b0;
                en_sub    <= 1'b0;
                out_addr  <= '0;
            end
        end
    end

endmodule

// File: doc/cen_sequencer.md
Name: cen_sequencer

Overview:
- Single-clock sequencer for the centering datapath (accumulator → mean divider → subtractor).
- Replaces gated per-stage clocks with clock-enable strobes.
- Walks a sample buffer twice:
  - pass 1 accumulates all samples;
  - a fixed-latency divider wait converts the sums to means;
  - pass 2 streams mean-subtracted samples downstream under a valid/ready handshake.
- Sits between the whitening top level (go/busy/done) and the sample buffer plus centering arithmetic stages.

Parameters:
- N_SAMPLES, 1024, number of samples per channel; must be a power of two, ≥2.
- ADDR_W, 10, sample-buffer address width; equals log2(N_SAMPLES).
- DIV_LAT, 4, divider latency in cycles from div_start to valid means; must be ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start request; sampled only in IDLE.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse on completion.
- rd_en  out  1  sample-buffer read strobe; data returns next cycle; the buffer holds rdata while rd_en=0.
- rd_addr  out  ADDR_W  sample-buffer read address.
- clr_sum  out  1  clear the accumulators.
- en_sum  out  1  accumulate the current buffer data.
- div_start  out  1  one-cycle pulse that launches the divider on the final sums.
- en_div  out  1  one-cycle pulse that latches the divider result into the mean registers.
- en_sub  out  1  subtractor result is valid this cycle.
- out_valid  out  1  centered sample presented downstream.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_addr  out  ADDR_W  index of the centered sample presented.

Behaviour:
- Reset:
  - rst=1 at any edge forces IDLE, including mid-operation.
  - All outputs go to 0 and both counters go to 0; no done pulse is emitted.
- States: IDLE, CLEAR, SUM, SUM_DRAIN, DIV, SUB, SUB_DRAIN, DONE.
- IDLE:
  - go=1 at an edge → CLEAR.
  - go is ignored in every other state; no queuing.
- CLEAR: one cycle, clr_sum=1, then SUM.
- SUM: N_SAMPLES cycles.
  - rd_en=1 each cycle; rd_addr counts 0..N_SAMPLES-1.
  - After rd_addr=N_SAMPLES-1 → SUM_DRAIN.
- en_sum is rd_en delayed one cycle, asserted only for reads issued in SUM. It is therefore high for the N_SAMPLES cycles starting the cycle after SUM entry.
- SUM_DRAIN: one cycle.
  - en_sum=1 for the last sample; rd_en=0.
  - Then DIV, with the counter reset to 0.
- DIV: exactly DIV_LAT cycles.
  - div_start=1 in the first cycle.
  - en_div=1 in the last cycle (counter = DIV_LAT-1).
  - Then SUB with the address counter reset to 0.
- SUB: issue/accept rules.
  - A read is issued (rd_en=1) only when (!out_valid | out_ready).
  - out_valid and en_sub register the issued read one cycle later.
  - out_addr registers rd_addr one cycle later.
  - If out_valid=1 and out_ready=0: out_valid, out_addr and en_sub hold; no read is issued; rd_addr holds.
  - After issuing address N_SAMPLES-1 → SUB_DRAIN.
- SUB_DRAIN:
  - No reads.
  - Holds until the final sample (out_addr=N_SAMPLES-1) is accepted, then DONE.
  - If that sample is accepted on the first SUB_DRAIN cycle, the state leaves after one cycle.
- DONE: one cycle, done=1, busy=1, then IDLE.
- busy deasserts the cycle after done.
- Address counter:
  - ADDR_W bits; terminal count is detected at N_SAMPLES-1.
  - No wrap is visible: the counter is reset on phase entry and never increments past terminal.
- DIV counter: $clog2(DIV_LAT)+1 bits.
- Mutual exclusion:
  - clr_sum, en_sum and en_div are never high together.
  - en_div and en_sub are never high together.
  - div_start and en_div are never high together, guaranteed by DIV_LAT≥2.
- Busy cycle count with out_ready stuck high: 2·N_SAMPLES + DIV_LAT + 4.

Decomposition:
- Shared package cen_pkg holds:
  - the state enum cen_state_t (3 bits);
  - constant CEN_RD_LAT=1.
- One sub-module, cen_addr_cnt: a loadable address counter with enable, sync clear and terminal-count flag.
  - It is instantiated once and reused by both passes.
- The FSM and the output-register pipeline remain in cen_sequencer.

Test Plan:
- Common bench settings: N_SAMPLES=8, ADDR_W=3, DIV_LAT=3.
- Nominal run: go pulse in IDLE with out_ready=1 → the following must all hold:
  - busy=1 for exactly 23 cycles;
  - clr_sum is 1 cycle;
  - rd_addr runs 0..7 twice;
  - en_sum is high for 8 cycles, lagging rd_en by 1;
  - div_start and en_div are 2 cycles apart;
  - out_addr runs 0..7 on consecutive cycles;
  - done pulses once in the last busy cycle.
- Backpressure: hold out_ready=0 for 3 cycles while out_addr=2 is valid →
  - out_addr stays 2 and rd_en=0 during the stall;
  - resumption yields 3..7 with no duplicate or skipped index;
  - busy lengthens by exactly 3 cycles.
- Final-sample stall: out_ready=0 while out_addr=7 for 5 cycles →
  - the FSM stays in SUB_DRAIN;
  - done fires the cycle after acceptance.
- Ignored go: pulse go during SUM and DIV → no restart; cycle counts identical to the nominal run.
- Reset mid-operation: assert rst for 1 cycle while in DIV →
  - next cycle all outputs are 0 and busy=0, with no done pulse;
  - a subsequent go produces a full nominal 23-cycle run.
- Back-to-back runs: go asserted in the cycle after done → a second run starts from CLEAR with rd_addr=0 and identical timing.
